mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/dm_defs.sv | 44 ++++
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/dm_load_align.sv | 31 +++
 rtl/mem_access_unit.sv | 128 ++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_defs.sv
// Shared definitions for the data-memory access unit: FSM states, access
// modes, default timeout and the store lane helpers.
package dm_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dm_state_t;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  localparam int DEF_TIMEOUT_CYC = 64;

  // Undefined modes (011/110/111) fall into the word rules everywhere.
  function automatic logic is_aligned(input logic [2:0] mode, input logic [1:0] a);
    case (mode)
      MODE_B, MODE_BU: is_aligned = 1'b1;
      MODE_H, MODE_HU: is_aligned = ~a[0];
      default:         is_aligned = (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] mode, input logic [1:0] a);
    case (mode)
      MODE_B, MODE_BU: store_strb = 4'b0001 << a;
      MODE_H, MODE_HU: store_strb = 4'b0011 << {a[1], 1'b0};
      default:         store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] mode, input logic [31:0] d);
    case (mode)
      MODE_B, MODE_BU: store_data = {4{d[7:0]}};
      MODE_H, MODE_HU: store_data = {2{d[15:0]}};
      default:         store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide request/acknowledge bus between the access unit and data memory.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dm_load_align.sv
// Picks the addressed byte/half out of a bus word and sign/zero extends it.
module dm_load_align
  import dm_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mode,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  always_comb begin
    byte_sel = lane[addr_lo];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (mode)
      MODE_B:  data = {{24{byte_sel[7]}}, byte_sel};
      MODE_BU: data = {24'h0, byte_sel};
      MODE_H:  data = {{16{half_sel[15]}}, half_sel};
      MODE_HU: data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline data-memory access unit: turns EX/MEM load/store requests into
// single bus transactions, stalling the pipeline until the access finishes.
module mem_access_unit
  import dm_defs::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmrd,
  input  logic              dmwe,
  input  logic [2:0]        dmu_mode,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_data,
  mem_access_unit_if.master bus,
  output logic              stall,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              misalign,
  output logic              bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  dm_state_t   state_reg, state_next;
  logic [7:0]  cnt_reg;
  logic        bus_req_reg, bus_we_reg;
  logic [31:0] bus_addr_reg, bus_wdata_reg;
  logic [3:0]  bus_wstrb_reg;
  logic        is_load_reg;
  logic [2:0]  mode_reg;
  logic [1:0]  addr_lo_reg;
  logic [31:0] rd_data_reg;
  logic        rd_valid_reg, bus_err_reg;

  logic        req, aligned, accept, timeout;
  logic [31:0] load_data;

  dm_load_align u_load_align (
    .rdata   (bus.bus_rdata),
    .addr_lo (addr_lo_reg),
    .mode    (mode_reg),
    .data    (load_data)
  );

  assign req     = dmrd | dmwe;
  assign aligned = is_aligned(dmu_mode, dm_addr[1:0]);
  assign accept  = (state_reg == ST_IDLE) && req && aligned;
  assign timeout = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: if (bus.bus_ack || timeout) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Stall asserts in the request cycle itself so the pipeline never slips past it.
  assign stall    = !rst && (accept || (state_reg == ST_BUSY));
  assign misalign = !rst && (state_reg == ST_IDLE) && req && !aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_wstrb_reg <= '0;
      is_load_reg   <= 1'b0;
      mode_reg      <= MODE_W;
      addr_lo_reg   <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            // A simultaneous load+store request executes as the store.
            bus_req_reg   <= 1'b1;
            bus_we_reg    <= dmwe;
            bus_addr_reg  <= {dm_addr[31:2], 2'b00};
            bus_wdata_reg <= store_data(dmu_mode, dm_data);
            bus_wstrb_reg <= dmwe ? store_strb(dmu_mode, dm_addr[1:0]) : 4'b0000;
            is_load_reg   <= !dmwe;
            mode_reg      <= dmu_mode;
            addr_lo_reg   <= dm_addr[1:0];
            cnt_reg       <= '0;
          end
        end
        ST_BUSY: begin
          if (bus.bus_ack) begin
            bus_req_reg <= 1'b0;
            if (is_load_reg) begin
              rd_data_reg  <= load_data;
              rd_valid_reg <= 1'b1;
            end
          end else if (timeout) begin
            bus_req_reg <= 1'b0;
            bus_err_reg <= 1'b1;
            rd_data_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_req   = bus_req_reg;
  assign bus.bus_we    = bus_we_reg;
  assign bus.bus_addr  = bus_addr_reg;
  assign bus.bus_wdata = bus_wdata_reg;
  assign bus.bus_wstrb = bus_wstrb_reg;
  assign rd_data       = rd_data_reg;
  assign rd_valid      = rd_valid_reg;
  assign bus_err       = bus_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout,
// back-to-back accesses and reset during a bus transaction.
module tb_mem_access_unit;
  import dm_defs::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmrd, dmwe;
  logic [2:0]  dmu_mode;
  logic [31:0] dm_addr, dm_data;
  logic        stall, rd_valid, misalign, bus_err;
  logic [31:0] rd_data;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .dmrd     (dmrd),
    .dmwe     (dmwe),
    .dmu_mode (dmu_mode),
    .dm_addr  (dm_addr),
    .dm_data  (dm_data),
    .bus      (bus_if),
    .stall    (stall),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .misalign (misalign),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Results of the most recent access() call.
  int          r_stall, r_req, r_rdv, r_err, r_mis;
  int          r_start, r_treq, r_done;
  logic [31:0] r_rd, r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we, r_stable, r_ended;
  // Results of the most recent idle() call.
  int          i_req, i_rdv, i_err, i_mis, i_stall;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic        rd;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } st_vec_t;

  ld_vec_t lv [5] = '{
    '{MODE_B,  32'h103, 32'h80FF_1234, 32'hFFFF_FF80},
    '{MODE_BU, 32'h103, 32'h80FF_1234, 32'h0000_0080},
    '{MODE_H,  32'h102, 32'h80FF_1234, 32'hFFFF_80FF},
    '{MODE_HU, 32'h100, 32'h80FF_1234, 32'h0000_1234},
    '{MODE_B,  32'h101, 32'h80FF_1234, 32'h0000_0012}
  };

  st_vec_t sv [5] = '{
    '{1'b0, MODE_B, 32'h201, 32'h0000_00AB, 32'h200, 4'b0010, 32'hABAB_ABAB},
    '{1'b0, MODE_H, 32'h202, 32'h1234_BEEF, 32'h200, 4'b1100, 32'hBEEF_BEEF},
    '{1'b0, MODE_W, 32'h204, 32'hCAFE_F00D, 32'h204, 4'b1111, 32'hCAFE_F00D},
    '{1'b0, MODE_B, 32'h200, 32'hFFFF_FF5A, 32'h200, 4'b0001, 32'h5A5A_5A5A},
    '{1'b1, MODE_H, 32'h300, 32'h0000_7777, 32'h300, 4'b0011, 32'h7777_7777}
  };

  // Drives one request and holds it while stalled, acting as a memory that
  // acks in the ack_at-th cycle of bus_req (0 = never). Returns at the first
  // cycle with stall low, leaving the request on the inputs.
  task automatic access(input logic rd, input logic we, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int ack_at, input logic [31:0] rdata);
    r_stall = 0; r_req = 0; r_rdv = 0; r_err = 0; r_mis = 0;
    r_treq = -1; r_done = -1; r_start = -1;
    r_rd = '0; r_addr = '0; r_wdata = '0; r_wstrb = '0; r_we = 1'b0;
    r_stable = 1'b1; r_ended = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        dmrd = rd; dmwe = we; dmu_mode = mode; dm_addr = addr; dm_data = data;
        r_start = cyc;
      end
      bus_if.bus_ack   = bus_if.bus_req && (ack_at == r_req + 1);
      bus_if.bus_rdata = bus_if.bus_ack ? rdata : 32'h5A5A_5A5A;
      #1;
      if (stall)    r_stall++;
      if (misalign) r_mis++;
      if (bus_err)  r_err++;
      if (rd_valid) begin r_rdv++; r_rd = rd_data; end
      if (bus_if.bus_req) begin
        if (r_req == 0) begin
          r_treq = cyc; r_addr = bus_if.bus_addr; r_wdata = bus_if.bus_wdata;
          r_wstrb = bus_if.bus_wstrb; r_we = bus_if.bus_we;
        end else if (bus_if.bus_addr !== r_addr || bus_if.bus_wdata !== r_wdata ||
                     bus_if.bus_wstrb !== r_wstrb || bus_if.bus_we !== r_we) begin
          r_stable = 1'b0;
        end
        r_req++;
      end
      if (!stall) begin
        r_done = cyc; r_ended = 1'b1;
        break;
      end
    end
    $display("access rd=%0b we=%0b mode=%03b addr=%h -> req=%0d stall=%0d rdv=%0d rd=%h err=%0d mis=%0d",
             rd, we, mode, addr, r_req, r_stall, r_rdv, r_rd, r_err, r_mis);
  endtask

  task automatic idle(input int n, input logic ack);
    i_req = 0; i_rdv = 0; i_err = 0; i_mis = 0; i_stall = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      dmrd = 1'b0; dmwe = 1'b0;
      bus_if.bus_ack = ack; bus_if.bus_rdata = 32'hFFFF_FFFF;
      #1;
      if (bus_if.bus_req) i_req++;
      if (rd_valid)       i_rdv++;
      if (bus_err)        i_err++;
      if (misalign)       i_mis++;
      if (stall)          i_stall++;
    end
    bus_if.bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmrd = 1'b1; dmwe = 1'b0; dmu_mode = MODE_W; dm_addr = 32'h40; dm_data = 32'h1;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    repeat (3) @(posedge clk);
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (bus_if.bus_req !== 1'b0 || bus_if.bus_we !== 1'b0) begin bad++; $display("FAIL rst_req_we got=%b%b exp=00", bus_if.bus_req, bus_if.bus_we); end
    total++; if (bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0 || bus_if.bus_wstrb !== 4'h0) begin bad++; $display("FAIL rst_bus got=%h/%h/%h exp=0", bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb); end
    total++; if (rd_data !== 32'h0 || rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd got=%h/%b exp=0/0", rd_data, rd_valid); end
    total++; if (misalign !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b/%b exp=0/0", misalign, bus_err); end
    @(posedge clk); #1;
    rst = 1'b0; dmrd = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_lw();
    access(1'b1, 1'b0, MODE_W, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
    total++; if (!r_ended) begin bad++; $display("FAIL lw_end got=timeout exp=done"); end
    total++; if (r_stall !== 4) begin bad++; $display("FAIL lw_stall got=%0d exp=4", r_stall); end
    total++; if (r_req !== 3) begin bad++; $display("FAIL lw_req got=%0d exp=3", r_req); end
    total++; if (r_rdv !== 1 || r_rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%0d/%h exp=1/deadbeef", r_rdv, r_rd); end
    total++; if (r_addr !== 32'h100 || r_we !== 1'b0) begin bad++; $display("FAIL lw_bus got=%h/%b exp=00000100/0", r_addr, r_we); end
    total++; if (!r_stable) begin bad++; $display("FAIL lw_stable got=changed exp=held"); end
    total++; if (r_treq - r_start !== 1) begin bad++; $display("FAIL lw_req_lat got=%0d exp=1", r_treq - r_start); end
    idle(1, 1'b0);
  endtask

  task automatic test_min_latency();
    access(1'b1, 1'b0, MODE_W, 32'h104, 32'h0, 1, 32'h0123_4567);
    total++; if (r_done - r_start !== 2) begin bad++; $display("FAIL minlat_rdv got=%0d exp=2", r_done - r_start); end
    total++; if (r_stall !== 2) begin bad++; $display("FAIL minlat_stall got=%0d exp=2", r_stall); end
    total++; if (r_rd !== 32'h0123_4567) begin bad++; $display("FAIL minlat_data got=%h exp=01234567", r_rd); end
    idle(1, 1'b0);
  endtask

  task automatic test_load_extend();
    for (int i = 0; i < 5; i++) begin
      access(1'b1, 1'b0, lv[i].mode, lv[i].addr, 32'h0, 2, lv[i].rdata);
      total++; if (r_rdv !== 1 || r_rd !== lv[i].exp) begin bad++; $display("FAIL ld_ext[%0d] got=%0d/%h exp=1/%h", i, r_rdv, r_rd, lv[i].exp); end
      total++; if (r_addr !== {lv[i].addr[31:2], 2'b00}) begin bad++; $display("FAIL ld_addr[%0d] got=%h exp=%h", i, r_addr, {lv[i].addr[31:2], 2'b00}); end
      idle(1, 1'b0);
    end
  endtask

  task automatic test_store();
    for (int i = 0; i < 5; i++) begin
      access(sv[i].rd, 1'b1, sv[i].mode, sv[i].addr, sv[i].data, 2, 32'h0BAD_0BAD);
      total++; if (r_addr !== sv[i].exp_addr || r_we !== 1'b1) begin bad++; $display("FAIL st_addr[%0d] got=%h/%b exp=%h/1", i, r_addr, r_we, sv[i].exp_addr); end
      total++; if (r_wstrb !== sv[i].exp_strb) begin bad++; $display("FAIL st_strb[%0d] got=%b exp=%b", i, r_wstrb, sv[i].exp_strb); end
      total++; if (r_wdata !== sv[i].exp_wdata) begin bad++; $display("FAIL st_wdata[%0d] got=%h exp=%h", i, r_wdata, sv[i].exp_wdata); end
      idle(2, 1'b0);
      total++; if (r_rdv + i_rdv !== 0) begin bad++; $display("FAIL st_rdv[%0d] got=%0d exp=0", i, r_rdv + i_rdv); end
      total++; if (rd_data !== 32'h0000_0012) begin bad++; $display("FAIL st_hold[%0d] got=%h exp=00000012", i, rd_data); end
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  m [4];
    logic [31:0] a [4];
    m = '{MODE_W, MODE_H, 3'b011, MODE_HU};
    a = '{32'h102, 32'h101, 32'h101, 32'h203};
    for (int i = 0; i < 4; i++) begin
      access(1'b1, (i == 3), m[i], a[i], 32'h55, 1, 32'h0);
      total++; if (r_mis !== 1 || r_stall !== 0 || r_req !== 0) begin bad++; $display("FAIL mis[%0d] got=mis%0d/stall%0d/req%0d exp=1/0/0", i, r_mis, r_stall, r_req); end
      idle(3, 1'b0);
      total++; if (i_req + i_mis + i_stall + i_rdv !== 0) begin bad++; $display("FAIL mis_after[%0d] got=%0d exp=0", i, i_req + i_mis + i_stall + i_rdv); end
    end
  endtask

  task automatic test_timeout();
    access(1'b1, 1'b0, MODE_W, 32'h108, 32'h0, 0, 32'h0);
    total++; if (!r_ended) begin bad++; $display("FAIL to_end got=hang exp=done"); end
    total++; if (r_req !== TO) begin bad++; $display("FAIL to_req got=%0d exp=%0d", r_req, TO); end
    total++; if (r_err !== 1 || r_rdv !== 0) begin bad++; $display("FAIL to_err got=%0d/%0d exp=1/0", r_err, r_rdv); end
    total++; if (r_stall !== TO + 1) begin bad++; $display("FAIL to_stall got=%0d exp=%0d", r_stall, TO + 1); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL to_rd got=%h exp=0", rd_data); end
    idle(2, 1'b1);
    total++; if (i_err + i_stall + i_rdv + i_req !== 0) begin bad++; $display("FAIL to_after got=%0d exp=0", i_err + i_stall + i_rdv + i_req); end
  endtask

  task automatic test_back_to_back();
    int done1;
    access(1'b1, 1'b0, MODE_W, 32'h10C, 32'h0, 1, 32'h1111_1111);
    done1 = r_done;
    total++; if (r_rd !== 32'h1111_1111) begin bad++; $display("FAIL b2b_first got=%h exp=11111111", r_rd); end
    access(1'b1, 1'b0, MODE_BU, 32'h10D, 32'h0, 2, 32'h0000_AB00);
    total++; if (r_treq - done1 !== 2) begin bad++; $display("FAIL b2b_gap got=%0d exp=2", r_treq - done1); end
    total++; if (r_req !== 2 || r_rd !== 32'h0000_00AB) begin bad++; $display("FAIL b2b_second got=%0d/%h exp=2/000000ab", r_req, r_rd); end
    idle(1, 1'b0);
  endtask

  task automatic test_rst_busy();
    @(posedge clk); #1;
    dmrd = 1'b1; dmwe = 1'b0; dmu_mode = MODE_W; dm_addr = 32'h110;
    @(posedge clk); #2;
    total++; if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL rb_req1 got=%b exp=1", bus_if.bus_req); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rb_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    rst = 1'b0; dmrd = 1'b0; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h9999_9999;
    #1;
    total++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rb_drop got=%b/%b exp=0/0", bus_if.bus_req, stall); end
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0;
    #1;
    total++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin bad++; $display("FAIL rb_late_ack got=%b/%h exp=0/0", rd_valid, rd_data); end
    $display("reset during busy checked");
    access(1'b1, 1'b0, MODE_W, 32'h114, 32'h0, 1, 32'h1357_9BDF);
    total++; if (r_treq - r_start !== 1 || r_rdv !== 1 || r_rd !== 32'h1357_9BDF) begin bad++; $display("FAIL rb_next got=%0d/%0d/%h exp=1/1/13579bdf", r_treq - r_start, r_rdv, r_rd); end
    idle(1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_min_latency();
    test_load_extend();
    test_store();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_rst_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
